ghost_chaser: RTL and testbench
===============================

Name: ghost_chaser

Overview:
- Moves the four enemy ghosts (red, blue, yellow, pink) across the 32x36-tile maze, toward Pac-Man's position.
- Updates once per video frame: on each frame strobe it checks walls for every ghost through a read-only tile port, then publishes all new ghost coordinates together.
- Sits between the Pac-Man movement block (source of Pac-Man's position) and the enemy sprite renderer (consumer of ghost coordinates).

Parameters:
- HOME_X, 88: x pixel of ghost 0. Ghost i starts at x = HOME_X + 16*i (order red=0, blue=1, yellow=2, pink=3).
- HOME_Y, 136: y pixel of all ghosts at reset.
- STEP, 1: pixels moved per accepted move.
- WALL_MIN, 3: any tile code >= WALL_MIN is a wall. Codes 0 (empty), 1 (candy) and 2 (power cookie) are walkable.

Ports:
- vga_pix_clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- frame_stb  in  1  one-cycle pulse at the start of each frame.
- x_pac, y_pac  in  9 each  Pac-Man sprite top-left pixel.
- tile_addr  out  11  map read address = (x/8) + (y/8)*32, range 0..1151.
- tile_data  in  4  tile code for tile_addr, valid one cycle after the address is presented.
- x_red, y_red, x_blue, y_blue, x_yellow, y_yellow, x_pink, y_pink  out  9 each  ghost sprite top-left pixels.
- busy  out  1  high while an update is in progress.

Behaviour:
- Reset (rst=0, asynchronous): all ghost outputs go to their home coordinates, busy=0, tile_addr=0, FSM=IDLE.
- A reset during an update aborts it; no partial positions are published.
- FSM states: IDLE -> PLAN -> PROBE -> DECIDE -> (next ghost PLAN | COMMIT) -> IDLE.
- IDLE: frame_stb=1 latches x_pac/y_pac and sets busy. frame_stb while busy is ignored.
- PLAN, for ghost i:
  - dx = x_pac - xi, dy = y_pac - yi (signed, 10-bit).
  - Red and yellow use horizontal-first; blue and pink use vertical-first.
  - The first candidate moves STEP along the preferred axis toward the target. The second candidate moves along the other axis.
  - An axis whose delta is 0 yields no candidate.
- PROBE, for candidate (x', y'):
  - Reads the four corner tiles (x',y'), (x'+7,y'), (x',y'+7), (x'+7,y'+7) one address per cycle. Each result is sampled the cycle after its address.
  - The candidate is blocked if any corner tile >= WALL_MIN.
  - The candidate is also blocked if x' < 0, y' < 0, x'+7 > 255 or y'+7 > 287; no read is issued in that case.
- DECIDE: the first unblocked candidate becomes ghost i's pending position. If both candidates are blocked, or there is no candidate, the ghost stays put.
- COMMIT: all eight outputs update in the same cycle, then busy=0. The whole update completes within 80 cycles of frame_stb.
- Outputs stay stable between commits.
- Ghosts ignore each other; overlapping ghosts are legal.
- Arithmetic is done in 10-bit signed and truncated to 9 bits only after the range check passes.

Optional Feature:
- Macro CATCH_DETECT_EN.
  - Defined: adds output caught_stb (1 bit). It pulses for exactly one cycle in the COMMIT cycle if any newly committed ghost satisfies |xg - x_pac| < 8 and |yg - y_pac| < 8, using the latched Pac-Man position. caught_stb resets to 0.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 -> ghost positions are (88,136), (104,136), (120,136), (136,136); busy=0. Release, no frame_stb -> outputs unchanged.
- Open map (all tiles 0), Pac-Man at (200,136), one frame_stb -> red (89,136), blue (105,136), yellow (121,136), pink (137,136). busy drops within 80 cycles.
- Open map, Pac-Man at (88,100): one frame -> red (88,135); blue (104,135), since it is vertical-first with dy<0. Red does not move in x because dx=0.
- Walls: tile code 3 directly right of red's box, Pac-Man at (200,100) -> red falls back to (88,135). With walls both right of and above red -> red stays at (88,136).
- frame_stb pulsed again while busy -> ignored; exactly one step is committed. Assert rst mid-update -> all ghosts return home and busy=0.
- With CATCH_DETECT_EN, Pac-Man at (89,136) -> caught_stb pulses for exactly 1 cycle in the COMMIT cycle. Without the macro, the port is absent.

Source files
------------

// File: rtl/ghost_chaser.sv
// ghost_chaser: once per video frame, steps the four ghosts (red, blue,
// yellow, pink) one move toward Pac-Man, checking the maze through a
// one-cycle-latency tile port. New coordinates are published together.
// Optional feature macro: CATCH_DETECT_EN (adds caught_stb).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for frame_stb; Pac-Man position latched on entry exit
// PLAN   | build up to two candidate moves for the current ghost
// PROBE  | read four corner tiles of the candidate (or reject out-of-range)
// DECIDE | accept candidate, retry with the fallback, or keep the ghost put
// COMMIT | publish all pending positions at once
module ghost_chaser #(
    parameter int HOME_X   = 88,
    parameter int HOME_Y   = 136,
    parameter int STEP     = 1,
    parameter int WALL_MIN = 3
) (
    input  logic        vga_pix_clk,
    input  logic        rst,
    input  logic        frame_stb,
    input  logic [8:0]  x_pac,
    input  logic [8:0]  y_pac,
    output logic [10:0] tile_addr,
    input  logic [3:0]  tile_data,
    output logic [8:0]  x_red,
    output logic [8:0]  y_red,
    output logic [8:0]  x_blue,
    output logic [8:0]  y_blue,
    output logic [8:0]  x_yellow,
    output logic [8:0]  y_yellow,
    output logic [8:0]  x_pink,
    output logic [8:0]  y_pink,
`ifdef CATCH_DETECT_EN
    output logic        caught_stb,
`endif
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, PLAN, PROBE, DECIDE, COMMIT} state_t;

    state_t state, state_nx;

    logic [8:0]        xs [4];
    logic [8:0]        ys [4];
    logic [8:0]        nx [4];
    logic [8:0]        ny [4];
    logic [8:0]        xp, yp;
    logic [1:0]        gi;
    logic [2:0]        idx;
    logic              blk;
    logic signed [9:0] cand_x, cand_y, alt_x, alt_y;
    logic              cand_valid, alt_valid;

    logic [8:0]        xg, yg;
    logic signed [9:0] xg_s, yg_s, dx, dy, hx, vy, step_s;
    logic              h_ok, v_ok, horiz_first;
    logic signed [9:0] first_x, first_y, second_x, second_y;
    logic              first_ok, second_ok;
    logic              oor, no_read;
    logic [10:0]       cx, cy;

    // Candidate generation for the ghost currently being planned.
    always_comb begin
        xg          = xs[gi];
        yg          = ys[gi];
        xg_s        = $signed({1'b0, xg});
        yg_s        = $signed({1'b0, yg});
        step_s      = 10'(STEP);
        dx          = $signed({1'b0, xp}) - xg_s;
        dy          = $signed({1'b0, yp}) - yg_s;
        h_ok        = (dx != 10'sd0);
        v_ok        = (dy != 10'sd0);
        hx          = dx[9] ? xg_s - step_s : xg_s + step_s;
        vy          = dy[9] ? yg_s - step_s : yg_s + step_s;
        // red (0) and yellow (2) prefer horizontal moves
        horiz_first = ~gi[0];
        if (horiz_first) begin
            first_x  = hx;   first_y  = yg_s; first_ok  = h_ok;
            second_x = xg_s; second_y = vy;   second_ok = v_ok;
        end else begin
            first_x  = xg_s; first_y  = vy;   first_ok  = v_ok;
            second_x = hx;   second_y = yg_s; second_ok = h_ok;
        end
    end

    // Range check and corner address for the candidate under probe.
    always_comb begin
        oor     = cand_x[9] || cand_y[9] ||
                  (cand_x + 10'sd7 > 10'sd255) || (cand_y + 10'sd7 > 10'sd287);
        no_read = !cand_valid || oor;
        cx      = 11'(cand_x) + (idx[0] ? 11'd7 : 11'd0);
        cy      = 11'(cand_y) + (idx[1] ? 11'd7 : 11'd0);
    end

    // State register.
    always_ff @(posedge vga_pix_clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state and combinational outputs.
    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        tile_addr = 11'd0;
        case (state)
            IDLE:   if (frame_stb) state_nx = PLAN;
            PLAN:   state_nx = PROBE;
            PROBE: begin
                if (idx == 3'd0 && no_read) state_nx = DECIDE;
                else if (idx == 3'd4)       state_nx = DECIDE;
                if (!no_read && idx < 3'd4)
                    tile_addr = ((cy >> 3) * 11'd32) + (cx >> 3);
            end
            DECIDE: begin
                if (blk && alt_valid) state_nx = PROBE;
                else if (gi == 2'd3)  state_nx = COMMIT;
                else                  state_nx = PLAN;
            end
            COMMIT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latching, candidate probing, pending and published positions.
    always_ff @(posedge vga_pix_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                xs[i] <= 9'(HOME_X + 16 * i);
                ys[i] <= 9'(HOME_Y);
                nx[i] <= 9'(HOME_X + 16 * i);
                ny[i] <= 9'(HOME_Y);
            end
            xp         <= '0;
            yp         <= '0;
            gi         <= '0;
            idx        <= '0;
            blk        <= 1'b0;
            cand_x     <= '0;
            cand_y     <= '0;
            alt_x      <= '0;
            alt_y      <= '0;
            cand_valid <= 1'b0;
            alt_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (frame_stb) begin
                    xp <= x_pac;
                    yp <= y_pac;
                    gi <= '0;
                    for (int i = 0; i < 4; i++) begin
                        nx[i] <= xs[i];
                        ny[i] <= ys[i];
                    end
                end
                PLAN: begin
                    idx   <= '0;
                    blk   <= 1'b0;
                    alt_x <= second_x;
                    alt_y <= second_y;
                    if (first_ok) begin
                        cand_x     <= first_x;
                        cand_y     <= first_y;
                        cand_valid <= 1'b1;
                        alt_valid  <= second_ok;
                    end else begin
                        cand_x     <= second_x;
                        cand_y     <= second_y;
                        cand_valid <= second_ok;
                        alt_valid  <= 1'b0;
                    end
                end
                PROBE: begin
                    if (idx == 3'd0 && no_read) begin
                        blk <= 1'b1;
                    end else begin
                        // data for the previous corner arrives this cycle
                        if (idx != 3'd0 && tile_data >= 4'(WALL_MIN)) blk <= 1'b1;
                        idx <= idx + 3'd1;
                    end
                end
                DECIDE: begin
                    if (!blk) begin
                        nx[gi] <= cand_x[8:0];
                        ny[gi] <= cand_y[8:0];
                        gi     <= gi + 2'd1;
                    end else if (alt_valid) begin
                        cand_x    <= alt_x;
                        cand_y    <= alt_y;
                        alt_valid <= 1'b0;
                        idx       <= '0;
                        blk       <= 1'b0;
                    end else begin
                        gi <= gi + 2'd1;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < 4; i++) begin
                        xs[i] <= nx[i];
                        ys[i] <= ny[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_red    = xs[0];
    assign y_red    = ys[0];
    assign x_blue   = xs[1];
    assign y_blue   = ys[1];
    assign x_yellow = xs[2];
    assign y_yellow = ys[2];
    assign x_pink   = xs[3];
    assign y_pink   = ys[3];

`ifdef CATCH_DETECT_EN
    function automatic logic near(input logic [8:0] a, input logic [8:0] b);
        logic signed [9:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 10'sd8) && (d > -10'sd8);
    endfunction

    // Catch pulse during COMMIT, judged on the positions being published.
    always_comb begin
        caught_stb = 1'b0;
        if (state == COMMIT) begin
            for (int i = 0; i < 4; i++)
                if (near(nx[i], xp) && near(ny[i], yp)) caught_stb = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ghost_chaser.sv
// Directed bench for ghost_chaser with a one-cycle-latency tile memory model.
module tb_ghost_chaser;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_stb;
    logic [8:0]  x_pac, y_pac;
    logic [10:0] tile_addr;
    logic [3:0]  tile_data;
    logic [8:0]  gx [4];
    logic [8:0]  gy [4];
    logic        busy;
`ifdef CATCH_DETECT_EN
    logic        caught_stb;
`endif

    logic [3:0]  map [0:1151];

    int total = 0;
    int passed = 0;
    int failed = 0;

    ghost_chaser dut (
        .vga_pix_clk (clk),
        .rst         (rst),
        .frame_stb   (frame_stb),
        .x_pac       (x_pac),
        .y_pac       (y_pac),
        .tile_addr   (tile_addr),
        .tile_data   (tile_data),
        .x_red       (gx[0]),
        .y_red       (gy[0]),
        .x_blue      (gx[1]),
        .y_blue      (gy[1]),
        .x_yellow    (gx[2]),
        .y_yellow    (gy[2]),
        .x_pink      (gx[3]),
        .y_pink      (gy[3]),
`ifdef CATCH_DETECT_EN
        .caught_stb  (caught_stb),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Tile memory: data follows the address by one clock.
    always @(posedge clk) tile_data <= map[tile_addr];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ghosts(input string tag,
                              input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2, input int x3, input int y3);
        chk({tag, " red_x"},    int'(gx[0]), x0);
        chk({tag, " red_y"},    int'(gy[0]), y0);
        chk({tag, " blue_x"},   int'(gx[1]), x1);
        chk({tag, " blue_y"},   int'(gy[1]), y1);
        chk({tag, " yellow_x"}, int'(gx[2]), x2);
        chk({tag, " yellow_y"}, int'(gy[2]), y2);
        chk({tag, " pink_x"},   int'(gx[3]), x3);
        chk({tag, " pink_y"},   int'(gy[3]), y3);
    endtask

    task automatic clear_map();
        for (int i = 0; i < 1152; i++) map[i] = 4'd0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic pulse_frame();
        @(posedge clk);
        #1 frame_stb = 1'b1;
        @(posedge clk);
        #1 frame_stb = 1'b0;
    endtask

    // One frame update; cyc counts clock edges from the frame_stb edge to commit.
    task automatic run_frame(output int cyc, output bit done);
        pulse_frame();
        cyc = 1;
        while (busy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        done = !busy;
    endtask

    initial begin
        int  cyc;
        bit  done;
        bit  all_done;
        int  pulses;
        int  n;

        rst       = 1'b0;
        frame_stb = 1'b0;
        x_pac     = 9'd0;
        y_pac     = 9'd0;
        clear_map();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_ghosts("reset", 88, 136, 104, 136, 120, 136, 136, 136);
        chk("reset busy", int'(busy), 0);
        chk("reset tile_addr", int'(tile_addr), 0);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk_ghosts("idle", 88, 136, 104, 136, 120, 136, 136, 136);
        chk("idle busy", int'(busy), 0);

        // Open map, Pac-Man to the right on the same row
        x_pac = 9'd200; y_pac = 9'd136;
        run_frame(cyc, done);
        chk("open done", int'(done), 1);
        chk("open within 80", int'(cyc <= 80), 1);
        chk_ghosts("open", 89, 136, 105, 136, 121, 136, 137, 136);
        repeat (5) @(posedge clk);
        #1;
        chk_ghosts("stable", 89, 136, 105, 136, 121, 136, 137, 136);

        // Pac-Man above red: axis preference and dx=0 handling
        do_reset();
        x_pac = 9'd88; y_pac = 9'd100;
        run_frame(cyc, done);
        chk("up done", int'(done), 1);
        chk_ghosts("up", 88, 135, 104, 135, 119, 136, 136, 135);

        // Wall right of red: falls back to vertical move
        do_reset();
        map[17*32 + 12] = 4'd3;
        x_pac = 9'd200; y_pac = 9'd100;
        run_frame(cyc, done);
        chk("wall_r done", int'(done), 1);
        chk_ghosts("wall_r", 88, 135, 104, 135, 121, 136, 136, 135);

        // Walls right of and above red: red stays
        do_reset();
        map[16*32 + 11] = 4'd15;
        run_frame(cyc, done);
        chk("wall_ru done", int'(done), 1);
        chk_ghosts("wall_ru", 88, 136, 104, 135, 121, 136, 136, 135);
        clear_map();

        // frame_stb while busy is ignored: exactly one step
        do_reset();
        x_pac = 9'd200; y_pac = 9'd136;
        pulse_frame();
        repeat (4) @(posedge clk);
        #1 frame_stb = 1'b1;
        @(posedge clk);
        #1 frame_stb = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_ign done", int'(busy), 0);
        repeat (80) @(posedge clk);
        #1;
        chk("busy_ign idle", int'(busy), 0);
        chk_ghosts("busy_ign", 89, 136, 105, 136, 121, 136, 137, 136);

        // Reset in the middle of an update aborts it
        pulse_frame();
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk_ghosts("abort", 88, 136, 104, 136, 120, 136, 136, 136);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_ghosts("abort after", 88, 136, 104, 136, 120, 136, 136, 136);

        // Right maze edge: x'+7 must not exceed 255, so ghosts stop at 248
        x_pac = 9'd300; y_pac = 9'd136;
        all_done = 1'b1;
        for (int f = 0; f < 170; f++) begin
            run_frame(cyc, done);
            if (!done || cyc > 80) all_done = 1'b0;
        end
        chk("edge all frames", int'(all_done), 1);
        chk_ghosts("edge", 248, 136, 248, 136, 248, 136, 248, 136);

`ifdef CATCH_DETECT_EN
        // Catch pulse: red lands on Pac-Man
        do_reset();
        x_pac = 9'd89; y_pac = 9'd136;
        pulse_frame();
        pulses = 0;
        n = 0;
        while (busy && n < 200) begin
            if (caught_stb) begin
                pulses++;
                chk("catch in busy", int'(busy), 1);
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("catch low after", int'(caught_stb), 0);
        chk("catch pulses", pulses, 1);
        chk("catch red_x", int'(gx[0]), 89);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
